// File: rtl/discrete_mac_arbiter.sv
// Shared signed 16x16 multiplier arbitrated between NUM_REQ filter stages.
// Latency: result 2 cycles after acceptance; fully pipelined, one acceptance per cycle.
// Backpressure: requesters hold req until gnt; frame-boundary overrun pulses flag requesters still waiting.
//
// Ports:
//   clk           - single clock, all logic on posedge
//   I_RST         - asynchronous, active-high reset
//   audio_clk_en  - one-cycle frame-start strobe
//   req/gnt       - per-requester request and combinational one-hot grant
//   op_a/op_b     - packed 16-bit signed operands, requester i at [16*i +: 16]
//   res/res_valid/res_id - scaled, saturated product, its strobe and owner index
//   overrun       - one-cycle pulse per requester unserved at a frame boundary
//
// Build option: define DISCRETE_MAC_ROUND_ROBIN_EN for round-robin priority;
// otherwise the lowest asserted index always wins.
module discrete_mac_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SHIFT   = 15
) (
    input  logic                         clk,
    input  logic                         I_RST,
    input  logic                         audio_clk_en,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*16-1:0]        op_a,
    input  logic [NUM_REQ*16-1:0]        op_b,
    output logic [NUM_REQ-1:0]           gnt,
    output logic signed [15:0]           res,
    output logic                         res_valid,
    output logic [$clog2(NUM_REQ)-1:0]   res_id,
    output logic [NUM_REQ-1:0]           overrun
);

    localparam int IDW = $clog2(NUM_REQ);

    // Acceptance decode and operand select
    logic                  acc_vld;
    logic [IDW-1:0]        acc_id;
    logic signed [15:0]    a_sel;
    logic signed [15:0]    b_sel;

    // Stage 1: full-width product
    logic signed [31:0]    prod_q, prod_d;
    logic                  vld1_q, vld1_d;
    logic [IDW-1:0]        id1_q, id1_d;

    // Stage 2: scaled and saturated result
    logic signed [31:0]    shifted;
    logic signed [15:0]    sat_res;
    logic signed [15:0]    res_q, res_d;
    logic                  res_valid_q, res_valid_d;
    logic [IDW-1:0]        res_id_q, res_id_d;

    // Frame-boundary tracking
    logic [NUM_REQ-1:0]    pend_q, pend_d;
    logic [NUM_REQ-1:0]    overrun_q, overrun_d;

`ifdef DISCRETE_MAC_ROUND_ROBIN_EN
    logic [IDW-1:0]        ptr_q, ptr_d;

    // Scan from the lowest priority position up to the pointer so the
    // last hit (closest to the pointer) is the one that sticks.
    always_comb begin
        int idx;
        idx = 0;
        gnt = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                gnt = NUM_REQ'(1) << idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (acc_vld) begin
            ptr_d = (acc_id == IDW'(NUM_REQ - 1)) ? '0 : acc_id + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: downward scan leaves the lowest asserted index.
    always_comb begin
        gnt = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                gnt = NUM_REQ'(1) << k;
            end
        end
    end
`endif

    // gnt is only ever raised on an asserted req, so any grant bit is an acceptance.
    always_comb begin
        acc_vld = 1'b0;
        acc_id  = '0;
        a_sel   = '0;
        b_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                acc_vld = 1'b1;
                acc_id  = IDW'(i);
                a_sel   = op_a[i*16 +: 16];
                b_sel   = op_b[i*16 +: 16];
            end
        end
    end

    // Operands are consumed straight into the product register on the accept edge.
    always_comb begin
        prod_d = a_sel * b_sel;
        vld1_d = acc_vld;
        id1_d  = acc_id;
    end

    always_comb begin
        shifted = prod_q >>> SHIFT;
        if (shifted > 32'sd32767) begin
            sat_res = 16'sh7fff;
        end else if (shifted < -32'sd32768) begin
            sat_res = 16'sh8000;
        end else begin
            sat_res = shifted[15:0];
        end
    end

    // res and res_id hold their last values between results.
    always_comb begin
        res_d       = res_q;
        res_id_d    = res_id_q;
        res_valid_d = vld1_q;
        if (vld1_q) begin
            res_d    = sat_res;
            res_id_d = id1_q;
        end
    end

    // A requester is pending after any cycle it asked and was passed over.
    // It is only reported if it was already waiting and is still waiting
    // (not granted, not withdrawn) when the frame strobe arrives.
    always_comb begin
        pend_d    = req & ~gnt;
        overrun_d = audio_clk_en ? (pend_q & req & ~gnt) : '0;
    end

    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            prod_q      <= '0;
            vld1_q      <= 1'b0;
            id1_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            pend_q      <= '0;
            overrun_q   <= '0;
        end else begin
            prod_q      <= prod_d;
            vld1_q      <= vld1_d;
            id1_q       <= id1_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            pend_q      <= pend_d;
            overrun_q   <= overrun_d;
        end
    end

    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_discrete_mac_arbiter.sv
// Bench for discrete_mac_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a reference model of grants, results and overruns.
module tb_discrete_mac_arbiter;

    localparam int NR = 4;
    localparam int SH = 15;

    logic                clk = 1'b0;
    logic                rst;
    logic                strobe;
    logic [NR-1:0]       req;
    logic [NR*16-1:0]    op_a;
    logic [NR*16-1:0]    op_b;
    logic [NR-1:0]       gnt;
    logic signed [15:0]  res;
    logic                res_valid;
    logic [1:0]          res_id;
    logic [NR-1:0]       overrun;

    always #5 clk = ~clk;

    discrete_mac_arbiter #(.NUM_REQ(NR), .SHIFT(SH)) dut (
        .clk          (clk),
        .I_RST        (rst),
        .audio_clk_en (strobe),
        .req          (req),
        .op_a         (op_a),
        .op_b         (op_b),
        .gnt          (gnt),
        .res          (res),
        .res_valid    (res_valid),
        .res_id       (res_id),
        .overrun      (overrun)
    );

    typedef struct {
        int due;
        int id;
        int val;
    } exp_t;

    exp_t          exp_q[$];
    int            a_v[NR];
    int            b_v[NR];
    int            checks   = 0;
    int            errors   = 0;
    int            cyc      = 0;
    int            ptr      = 0;
    int            last_res = 0;
    logic [NR-1:0] pend     = '0;
    logic [NR-1:0] ovr_next = '0;
    logic [NR-1:0] last_gnt = '0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Product scaled by 2^SH with rounding toward minus infinity, then clamped.
    function automatic int mac_ref(input int a, input int b);
        longint p;
        longint d;
        longint q;
        p = longint'(a) * longint'(b);
        d = longint'(1) << SH;
        q = p / d;
        if (p < 0 && (p % d) != 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    function automatic logic [NR-1:0] model_gnt(input logic [NR-1:0] r, input int p);
        logic [NR-1:0] g;
        int idx;
        g = '0;
        for (int k = 0; k < NR; k++) begin
            idx = (p + k) % NR;
            if (r[idx] && g == '0) g[idx] = 1'b1;
        end
        return g;
    endfunction

    function automatic int idx_of(input logic [NR-1:0] g);
        int r;
        r = 0;
        for (int i = 0; i < NR; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            op_a[i*16 +: 16] = a_v[i][15:0];
            op_b[i*16 +: 16] = b_v[i][15:0];
        end
    endtask

    // Called #1 after a rising edge with inputs set; checks this cycle,
    // advances the model across the next edge, returns #1 after it.
    // want_gnt >= 0 adds a directed grant comparison.
    task automatic tick(input int want_gnt);
        logic [NR-1:0] g;
        int id;
        drive();
        #3;
        if (rst) begin
            exp_q.delete();
            pend     = '0;
            ovr_next = '0;
            ptr      = 0;
            last_res = 0;
        end
        g = model_gnt(req, ptr);
        last_gnt = g;
        chk("gnt", 32'(gnt), 32'(g));
        if (want_gnt >= 0) chk("gnt_directed", 32'(gnt), want_gnt);
        if (!rst && exp_q.size() > 0 && exp_q[0].due == cyc) begin
            last_res = exp_q[0].val;
            chk("res_valid", 32'(res_valid), 1);
            chk("res_id", 32'(res_id), exp_q[0].id);
            void'(exp_q.pop_front());
        end else begin
            chk("res_valid", 32'(res_valid), 0);
        end
        chk("res", 32'(res), last_res);
        chk("overrun", 32'(overrun), 32'(ovr_next));
        if (!rst) begin
            ovr_next = strobe ? (pend & req & ~g) : '0;
            pend     = req & ~g;
            if (g != '0) begin
                id = idx_of(g);
                exp_q.push_back('{due: cyc + 2, id: id, val: mac_ref(a_v[id], b_v[id])});
`ifdef DISCRETE_MAC_ROUND_ROBIN_EN
                ptr = (id + 1) % NR;
`endif
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        req = '0;
        tick(0);
        rst = 1'b0;
    endtask

    initial begin
        logic [NR-1:0] keep;
        int            held_exp;
        rst    = 1'b1;
        strobe = 1'b0;
        req    = '0;
        for (int i = 0; i < NR; i++) begin
            a_v[i] = 0;
            b_v[i] = 0;
        end
        drive();
        #1;
        tick(0);
        tick(0);
        chk("reset_res", 32'(res), 0);
        chk("reset_valid", 32'(res_valid), 0);
        chk("reset_id", 32'(res_id), 0);
        chk("reset_overrun", 32'(overrun), 0);
        rst = 1'b0;

        // Single request
        req = 4'b0010; a_v[1] = 16384; b_v[1] = 16384;
        tick(2);
        req = '0;
        tick(0);
        chk("single_res", 32'(res), 8192);
        chk("single_valid", 32'(res_valid), 1);
        chk("single_id", 32'(res_id), 1);
        tick(0);
        chk("single_pulse", 32'(res_valid), 0);
        chk("single_hold", 32'(res), 8192);

        // Saturation, back-to-back
        req = 4'b0001; a_v[0] = -32768; b_v[0] = -32768;
        tick(1);
        a_v[0] = 32767;
        tick(1);
        req = '0;
        chk("sat_pos", 32'(res), 32767);
        tick(0);
        chk("sat_neg", 32'(res), -32767);
        chk("sat_b2b_valid", 32'(res_valid), 1);
        tick(0);

        // Contention, each requester drops on grant
        reset_pulse();
        req = 4'b1111;
        for (int i = 0; i < NR; i++) begin a_v[i] = 1000 * (i + 1); b_v[i] = 32767; end
        for (int k = 0; k < 4; k++) begin
            if (k >= 2) chk("drop_res_id", 32'(res_id), k - 2);
            tick(1 << k);
            req[k] = 1'b0;
        end
        chk("drop_res_id", 32'(res_id), 2);
        tick(0);
        chk("drop_res_id", 32'(res_id), 3);
        tick(0);
        tick(0);

        // Contention, requests held constantly
        reset_pulse();
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
`ifdef DISCRETE_MAC_ROUND_ROBIN_EN
            held_exp = 1 << k;
`else
            held_exp = 1;
`endif
            tick(held_exp);
        end
        req = '0;
        tick(0);
        tick(0);

        // Overrun on frame strobe
        reset_pulse();
        req = 4'b0101;
        tick(-1); tick(-1); tick(-1);
        strobe = 1'b1;
        tick(-1);
        strobe = 1'b0;
`ifndef DISCRETE_MAC_ROUND_ROBIN_EN
        chk("overrun_fixed", 32'(overrun), 4);
`endif
        tick(-1);
        chk("overrun_one_cycle", 32'(overrun), 0);
        req = '0;
        tick(0); tick(0);

        // Reset with a product in flight
        req = 4'b0001; a_v[0] = 20000; b_v[0] = 20000;
        tick(1);
        req = '0;
        rst = 1'b1;
        tick(0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("flush_valid", 32'(res_valid), 0);
            chk("flush_res", 32'(res), 0);
            tick(0);
        end

        // Frame strobe coinciding with acceptance of requester 3
        reset_pulse();
        req = 4'b1001; a_v[3] = -20000; b_v[3] = 30000;
        tick(-1); tick(-1);
        req = 4'b1000; strobe = 1'b1;
        tick(8);
        req = '0; strobe = 1'b0;
        chk("coincide_overrun", 32'(overrun), 0);
        tick(0);
        chk("coincide_valid", 32'(res_valid), 1);
        chk("coincide_id", 32'(res_id), 3);
        tick(0);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            rst    = ($urandom_range(0, 63) == 0);
            strobe = ($urandom_range(0, 5) == 0);
            keep   = req & ~last_gnt;
            if ($urandom_range(0, 7) == 0) keep = keep & NR'($urandom);
            req = keep | (NR'($urandom) & NR'($urandom));
            for (int i = 0; i < NR; i++) begin
                case ($urandom_range(0, 7))
                    0: a_v[i] = -32768;
                    1: a_v[i] = 32767;
                    default: a_v[i] = int'($urandom_range(0, 65535)) - 32768;
                endcase
                case ($urandom_range(0, 7))
                    0: b_v[i] = -32768;
                    1: b_v[i] = -1;
                    default: b_v[i] = int'($urandom_range(0, 65535)) - 32768;
                endcase
            end
            tick(-1);
        end
        rst = 1'b0; strobe = 1'b0; req = '0;
        tick(0); tick(0); tick(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/discrete_mac_arbiter.md
DISCRETE_MAC_ARBITER -- requirements
Module: discrete_mac_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesting filter stages (2..8).
REQ-002 SHALL have parameter SHIFT, default 15: right-shift applied to the product (fixed-point scaling).
REQ-003 SHALL have port clk, input, 1: single clock, all logic on posedge.
REQ-004 SHALL have port I_RST, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port audio_clk_en, input, 1: one-cycle sample strobe marking the start of each audio frame.
REQ-006 SHALL have port req, input, NUM_REQ: per-requester multiply request; held high until granted.
REQ-007 SHALL have port op_a, input, NUM_REQ x 16 signed: multiplicand per requester.
REQ-008 SHALL have port op_b, input, NUM_REQ x 16 signed: multiplier per requester.
REQ-009 SHALL have port gnt, output, NUM_REQ: one-hot grant, combinational from req and priority state.
REQ-010 SHALL have port res, output, 16 signed: scaled, saturated product.
REQ-011 SHALL have port res_valid, output, 1: res valid this cycle.
REQ-012 SHALL have port res_id, output, clog2(NUM_REQ): index of requester owning res.
REQ-013 SHALL have port overrun, output, NUM_REQ: one-cycle pulse per requester still unserved at a frame boundary.

Function
REQ-014 SHALL grant at most one requester per cycle; gnt SHALL be zero when req is zero.
REQ-015 SHALL treat a transfer as accepted in the cycle where req[i] and gnt[i] are both high; op_a[i] and op_b[i] SHALL be captured on that edge.
REQ-016 SHALL compute the full 32-bit signed product in the cycle after acceptance (stage 1 register).
REQ-017 SHALL arithmetic-shift the product right by SHIFT and saturate to [-32768, 32767] into res, with res_valid and res_id asserted exactly 2 cycles after acceptance.
REQ-018 SHALL sustain one acceptance per cycle (fully pipelined); back-to-back results SHALL appear on consecutive cycles in acceptance order.
REQ-019 SHALL track a per-requester pending flag: set when req[i] high and not granted, cleared on acceptance or when req[i] drops.
REQ-020 SHALL, on audio_clk_en, pulse overrun[i] for one cycle for every requester whose pending flag is set at that edge; arbitration SHALL continue unaffected.
REQ-021 SHALL, when audio_clk_en coincides with acceptance of requester i, not flag overrun[i].
REQ-022 SHALL hold res at its last value while res_valid is low.
REQ-023 SHALL deassert res_valid when no acceptance occurred 2 cycles earlier.

Reset
REQ-024 SHALL, while I_RST is high, force res=0, res_valid=0, res_id=0, overrun=0, pipeline stages and pending flags cleared, priority pointer at index 0.
REQ-025 SHALL discard any in-flight products when I_RST asserts mid-operation; no res_valid SHALL emerge for transfers accepted before reset.
REQ-026 SHALL accept requests from the first clk edge after I_RST deasserts.

Configuration
REQ-027 SHALL, with macro DISCRETE_MAC_ROUND_ROBIN_EN defined, use round-robin priority: after acceptance of index i, the highest priority SHALL move to (i+1) mod NUM_REQ.
REQ-028 SHALL, without DISCRETE_MAC_ROUND_ROBIN_EN, use fixed priority: the lowest asserted index always wins and the pointer is unused.

Verification
REQ-029 Single request: req=4'b0010, op_a=16384, op_b=16384 -> gnt=4'b0010 same cycle; 2 cycles later res=8192, res_id=1, res_valid=1 for one cycle.
REQ-030 Saturation: op_a=-32768, op_b=-32768, SHIFT=15 -> res=32767; op_a=32767, op_b=-32768 -> res=-32767.
REQ-031 Contention (round-robin): req=4'b1111 held, each dropped on grant -> grants 0,1,2,3 on 4 consecutive cycles, results res_id 0,1,2,3 on consecutive cycles; without macro, same order since grants are dropped, but with req held constantly high only index 0 is ever granted.
REQ-032 Overrun: fixed priority, req[0] and req[2] held high continuously, audio_clk_en pulse -> overrun=4'b0100 for one cycle, overrun[0]=0.
REQ-033 Reset mid-pipeline: accept a transfer, assert I_RST on next cycle for 1 cycle -> res_valid stays 0, res=0 for at least 3 cycles afterwards.
REQ-034 Coincident frame strobe: req[3] granted in same cycle as audio_clk_en -> overrun[3]=0, res_valid with res_id=3 two cycles later.
